seq_bin2bcd: RTL and testbench



---
 rtl/seq_bin2bcd_pkg.sv | 18 +
 rtl/seq_bin2bcd_adj.sv | 11 +
 rtl/seq_bin2bcd.sv | 116 +++++++++++
 tb/tb_seq_bin2bcd.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package seq_bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_bin2bcd_adj.sv
// Double-dabble digit correction cell: a BCD digit of 5 or more gets 3 added (4-bit wrap).
module bcd_digit_adj
  import seq_bin2bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= ADD3_THRESH) ? (digit_in + ADD3_VAL) : digit_in;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock, valid/ready on both sides.
// Optional two's-complement input with sign output: define SEQ_BIN2BCD_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// CONV  | BIN_W shift-add-3 iterations, busy high
// DONE  | result held on bcd, out_valid high until out_ready
module seq_bin2bcd
  import seq_bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef SEQ_BIN2BCD_SIGNED_EN
  output logic                  neg,
`endif
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int CAT_W = 4*DIGITS + BIN_W;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      sr_q, sr_shift, operand;
  logic [4*DIGITS-1:0]   acc_q, acc_adj, acc_shift, bcd_q;
  logic [CAT_W-1:0]      cat_shift;
  logic [CNT_W-1:0]      cnt_q;
  logic                  last_iter;

`ifdef SEQ_BIN2BCD_SIGNED_EN
  // |bin| always fits BIN_W unsigned bits, so the negation can stay at BIN_W.
  assign operand = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
`else
  assign operand = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .digit_in  (acc_q[4*g +: 4]),
      .digit_out (acc_adj[4*g +: 4])
    );
  end

  assign cat_shift = {acc_adj, sr_q} << 1;
  assign acc_shift = cat_shift[CAT_W-1:BIN_W];
  assign sr_shift  = cat_shift[BIN_W-1:0];
  assign last_iter = (cnt_q == CNT_W'(BIN_W-1));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q  <= operand;
            acc_q <= '0;
            cnt_q <= '0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
            neg   <= bin[BIN_W-1];
`endif
          end
        end
        CONV: begin
          sr_q  <= sr_shift;
          acc_q <= acc_shift;
          cnt_q <= cnt_q + CNT_W'(1);
          // Result register only moves on completion, so bcd is stable outside that edge.
          if (last_iter) bcd_q <= acc_shift;
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: latency, stall, abort-by-reset and operand-hold behaviour.
module tb_seq_bin2bcd;

  localparam int BIN_W  = 12;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [BIN_W-1:0]    bin = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
`ifdef SEQ_BIN2BCD_SIGNED_EN
  logic                neg;
`endif

  int checks   = 0;
  int failures = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  seq_bin2bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SEQ_BIN2BCD_SIGNED_EN
    .neg       (neg),
`endif
    .bcd       (bcd),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected {neg, bcd} by repeated division.
  function automatic logic [16:0] model(input logic [BIN_W-1:0] b);
    int          v;
    logic        negv;
    logic [15:0] r;
    v    = int'(b);
    negv = 1'b0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
    if (b[BIN_W-1]) begin
      v    = (1 << BIN_W) - v;
      negv = 1'b1;
    end
`endif
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {negv, r};
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        check_eq("bcd", 32'(bcd), 32'(e[15:0]));
`ifdef SEQ_BIN2BCD_SIGNED_EN
        check_eq("neg", 32'(neg), 32'(e[16]));
`endif
      end
    end
  end

  task automatic run_op(input logic [BIN_W-1:0] b, input logic [BIN_W-1:0] b_late, input int stall);
    int          n;
    logic [16:0] e;
    e = model(b);
    sb.push_back(e);
    out_ready = (stall == 0);
    bin       = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin      = b_late;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'(BIN_W));
    check_eq("done_in_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_bcd", 32'(bcd), 32'(e[15:0]));
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = (s == 0);
      bin      = 12'd99;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
    check_eq("idle_out_valid", 32'(out_valid), 32'd0);
    check_eq("bcd_hold", 32'(bcd), 32'(e[15:0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_bcd", 32'(bcd), 32'd0);
`ifdef SEQ_BIN2BCD_SIGNED_EN
    check_eq("rst_neg", 32'(neg), 32'd0);
`endif
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_op(12'd0,    12'hABC, 0);
    run_op(12'd4095, 12'd1,   0);
    run_op(12'd1234, 12'd0,   0);
    run_op(12'd35,   12'd77,  0);

    run_op(12'd4095, 12'd5,   5);
    @(posedge clk); #1;
    check_eq("ignored_op_busy", 32'(busy), 32'd0);
    check_eq("ignored_op_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      logic [BIN_W-1:0] r;
      r = BIN_W'($urandom_range(0, (1 << BIN_W) - 1));
      run_op(r, ~r, i % 2);
    end

    run_op(12'd500, 12'd9, 0);

    // Abort mid-conversion with an asynchronous reset.
    bin      = 12'd1000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_eq("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_bcd", 32'(bcd), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_op(12'd7, 12'd3, 0);

    run_op(12'hFFF, 12'h000, 0);
    run_op(12'h800, 12'h001, 0);
    run_op(12'h7FF, 12'h800, 0);

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
